sram_client_ctrl: RTL and testbench

Single-port initiator for the technology-cell SRAM macro wrapper: converts a valid/ready request stream into the SRAM's req/we/addr/wdata/be port and returns read data through a backpressurable response FIFO sized against the macro's fixed read latency. It optionally zero-fills the array after reset before accepting traffic. It sits between a cache/buffer controller and one port of the SRAM wrapper.

---
 rtl/sram_client_ctrl_if.sv | 27 ++
 rtl/sram_client_ctrl.sv | 148 ++++++++++++++
 tb/tb_sram_client_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_client_ctrl_if.sv
// Client-side request/response channel of sram_client_ctrl.
// master = cache/buffer controller, slave = sram_client_ctrl.
interface sram_client_ctrl_if #(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 128,
  parameter int BeWidth   = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic [BeWidth-1:0]   req_be;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DataWidth-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_client_ctrl.sv
// Single-port SRAM initiator with credit-guarded read-response FIFO.
// Define SRAM_CLIENT_INIT_EN to compile in the post-reset zero-fill sweep.
module sram_client_ctrl #(
  parameter int NumWords     = 1024,
  parameter int DataWidth    = 128,
  parameter int ByteWidth    = 8,
  parameter int Latency      = 1,
  parameter int RspFifoDepth = Latency + 2,
  localparam int AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sram_client_ctrl_if.slave    req_if,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 init_done_o
);
  localparam int CntW = $clog2(RspFifoDepth + 1);
  localparam int PtrW = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;

  logic run;
  logic accept;
  logic rd_acc;
  logic push;
  logic pop;

`ifdef SRAM_CLIENT_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [AddrWidth-1:0] sweep_q, sweep_d;

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + AddrWidth'(1);
      if (sweep_q == AddrWidth'(NumWords - 1)) state_d = ST_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign run         = (state_q == ST_RUN);
  assign init_done_o = run;
`else
  logic init_done_q, init_done_d;

  always_comb init_done_d = 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) init_done_q <= 1'b0;
    else       init_done_q <= init_done_d;
  end

  assign run         = 1'b1;
  assign init_done_o = init_done_q;
`endif

  logic [CntW-1:0]    credit_q, credit_d;
  logic [Latency-1:0] vld_sr_q, vld_sr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] fifo_mem [RspFifoDepth];

  // Credit covers both in-flight reads and queued responses, so the FIFO can never overflow.
  assign req_if.req_ready = !rst_i && run && (credit_q < CntW'(RspFifoDepth));
  assign accept           = req_if.req_valid && req_if.req_ready;
  assign rd_acc           = accept && !req_if.req_we;
  assign push             = vld_sr_q[Latency-1];
  assign req_if.rsp_valid = (count_q != '0);
  assign pop              = req_if.rsp_valid && req_if.rsp_ready;
  assign req_if.rsp_rdata = fifo_mem[rd_ptr_q];

  always_comb begin
    sram_req_o   = accept;
    sram_we_o    = req_if.req_we;
    sram_addr_o  = req_if.req_addr;
    sram_wdata_o = req_if.req_wdata;
    sram_be_o    = req_if.req_be;
`ifdef SRAM_CLIENT_INIT_EN
    if (!run) begin
      sram_req_o   = !rst_i;
      sram_we_o    = 1'b1;
      sram_addr_o  = sweep_q;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end
`endif
  end

  always_comb begin
    vld_sr_d[0] = rd_acc;
    for (int i = 1; i < Latency; i++) vld_sr_d[i] = vld_sr_q[i-1];

    credit_d = credit_q;
    if (rd_acc && !pop)      credit_d = credit_q + CntW'(1);
    else if (!rd_acc && pop) credit_d = credit_q - CntW'(1);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(RspFifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PtrW'(RspFifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q <= '0;
      vld_sr_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      credit_q <= credit_d;
      vld_sr_q <= vld_sr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= sram_rdata_i;
  end
endmodule

// File: tb/tb_sram_client_ctrl.sv
// Directed self-checking bench for sram_client_ctrl (16 x 32-bit, Latency 1, 3-entry FIFO).
// Expectations follow SRAM_CLIENT_INIT_EN the same way the design does.
module tb_sram_client_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sram_req, sram_we;
  logic [3:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata = '0;
  logic        init_done;
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] mem [16];
  logic [31:0] pat [8];

  sram_client_ctrl_if #(.AddrWidth(4), .DataWidth(32), .BeWidth(4)) bus ();

  sram_client_ctrl #(
    .NumWords(16), .DataWidth(32), .ByteWidth(8), .Latency(1), .RspFifoDepth(3)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_if       (bus.slave),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata),
    .init_done_o  (init_done)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM macro with a one-cycle registered read port.
  always @(posedge clk_i) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.req_valid = vld;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp5;
    bit          got;
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | i;
    pat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    rst_i = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

    // Reset state
    tick(); tick(); tick();
    bus.req_valid = 1'b1;
    settle();
    check("rst_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_sram_req", sram_req, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    rst_i = 1'b0;

`ifdef SRAM_CLIENT_INIT_EN
    for (int i = 0; i < 16; i++) begin
      settle();
      check("init_req", sram_req, 1'b1);
      check("init_we", sram_we, 1'b1);
      check("init_addr", sram_addr, i);
      check("init_wdata", sram_wdata, 32'h0);
      check("init_be", sram_be, 4'hF);
      check("init_ready", bus.req_ready, 1'b0);
      check("init_done_low", init_done, 1'b0);
      tick();
    end
    settle();
    check("init_done_rise", init_done, 1'b1);
    check("run_ready", bus.req_ready, 1'b1);
    exp5 = 32'h0;
`else
    settle();
    check("run_ready_first", bus.req_ready, 1'b1);
    tick();
    settle();
    check("init_done_rise", init_done, 1'b1);
    exp5 = 32'h66666666;
`endif

    // Write then read address 3
    drive(1'b1, 1'b1, 4'd3, 32'hA5A5A5A5, 4'hF);
    settle();
    check("wr_sram_req", sram_req, 1'b1);
    check("wr_sram_we", sram_we, 1'b1);
    check("wr_sram_addr", sram_addr, 4'd3);
    check("wr_sram_wdata", sram_wdata, 32'hA5A5A5A5);
    check("wr_sram_be", sram_be, 4'hF);
    tick();
    drive(1'b1, 1'b0, 4'd3, 32'h0, 4'hF);
    settle();
    check("rd_sram_req", sram_req, 1'b1);
    check("rd_sram_we", sram_we, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    settle();
    check("rd_lat_t1", bus.rsp_valid, 1'b0);
    tick();
    settle();
    check("rd_lat_t2", bus.rsp_valid, 1'b1);
    check("rd_data", bus.rsp_rdata, 32'hA5A5A5A5);
    tick();
    settle();
    check("rd_popped", bus.rsp_valid, 1'b0);

    // Fill addresses 0..7, then back-to-back reads with no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, i[3:0], pat[i], 4'hF);
      settle();
      check("fill_ready", bus.req_ready, 1'b1);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(k < 8, 1'b0, k[3:0], 32'h0, 4'hF);
      settle();
      if (k < 8) check("b2b_accept", sram_req, 1'b1);
      if (k >= 2) begin
        check("b2b_valid", bus.rsp_valid, 1'b1);
        check("b2b_data", bus.rsp_rdata, pat[k-2]);
      end
      tick();
    end
    settle();
    check("b2b_drained", bus.rsp_valid, 1'b0);

    // Backpressure: exactly three accepts, writes gated too, credit returns a cycle after pop
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd0, 32'h0, 4'hF);
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp_ready", bus.req_ready, k < 3);
      tick();
    end
    drive(1'b1, 1'b1, 4'd9, 32'h99999999, 4'hF);
    settle();
    check("bp_wr_ready", bus.req_ready, 1'b0);
    check("bp_wr_sram_req", sram_req, 1'b0);
    tick();
    bus.rsp_ready = 1'b1;
    settle();
    check("bp_pop_valid", bus.rsp_valid, 1'b1);
    check("bp_pop_data", bus.rsp_rdata, 32'h11111111);
    check("bp_no_reuse", bus.req_ready, 1'b0);
    tick();
    bus.rsp_ready = 1'b0;
    settle();
    check("bp_ready_back", bus.req_ready, 1'b1);
    check("bp_wr_issued", sram_req, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("bp_drain_valid", bus.rsp_valid, 1'b1);
      check("bp_drain_data", bus.rsp_rdata, 32'h11111111);
      tick();
    end
    settle();
    check("bp_empty", bus.rsp_valid, 1'b0);

    // Partial write: only byte 0 changes
    drive(1'b1, 1'b1, 4'd10, 32'hFFFFFFFF, 4'hF);
    tick();
    drive(1'b1, 1'b1, 4'd10, 32'h12345678, 4'h1);
    tick();
    drive(1'b1, 1'b0, 4'd10, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    tick();
    settle();
    check("be_valid", bus.rsp_valid, 1'b1);
    check("be_data", bus.rsp_rdata, 32'hFFFFFF78);
    tick();

    // Reset with reads in flight and a non-empty FIFO
    bus.rsp_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 1'b0, k[3:0], 32'h0, 4'hF);
      tick();
    end
    bus.req_valid = 1'b0;
    settle();
    check("pre_rst_valid", bus.rsp_valid, 1'b1);
    rst_i = 1'b1;
    bus.req_valid = 1'b1;
    settle();
    check("mid_rst_sram_req", sram_req, 1'b0);
    check("mid_rst_ready", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    settle();
    check("post_rst_valid", bus.rsp_valid, 1'b0);
    tick();
    rst_i = 1'b0;
    bus.rsp_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      settle();
      check("rst_no_stale", bus.rsp_valid, 1'b0);
      if (bus.req_ready) got = 1'b1;
      else tick();
    end
    check("rst_ready_timeout", got, 1'b1);
    drive(1'b1, 1'b0, 4'd5, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    tick();
    settle();
    check("addr5_valid", bus.rsp_valid, 1'b1);
    check("addr5_data", bus.rsp_rdata, exp5);
    tick();
    settle();
    check("final_empty", bus.rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
